// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between requesters, the arbiter and uart_tx.
// slave is the arbiter view; master is the requester/transmitter view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport slave (
        input  req_data,
        input  req_valid,
        input  req_last,
        output req_ready,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport master (
        output req_data,
        output req_valid,
        output req_last,
        input  req_ready,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx among requesters.
// Define UART_ARB_TIMEOUT_EN to force release of a stalled lock owner.
module uart_tx_arbiter #(
    parameter int  NUM_REQ        = 2,
    parameter int  TIMEOUT_CYCLES = 100000,
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus,
    output logic [OW-1:0]    owner,
    output logic             locked,
    output logic             timeout
);
    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state_q;
    logic [OW-1:0] owner_q;
    logic [OW-1:0] rr_q;
    logic [7:0]    txd_q;
    logic          txv_q;

    logic [OW-1:0] win;
    logic [OW-1:0] nxt;
    logic          found;
    logic          load_ok;
    logic          own_v;
    logic          own_l;
    logic [7:0]    own_d;
    logic          xfer;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          tmo_q;
`endif

    always_comb begin
        load_ok       = !txv_q || bus.tx_ready;
        own_v         = 1'b0;
        own_l         = 1'b0;
        own_d         = 8'h00;
        bus.req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == OW'(k)) begin
                own_v            = bus.req_valid[k];
                own_l            = bus.req_last[k];
                own_d            = bus.req_data[8*k +: 8];
                bus.req_ready[k] = (state_q == LOCK) && load_ok;
            end
        end
        xfer = (state_q == LOCK) && own_v && load_ok;
        // Two passes: at/after rr_q first, then wrap to the low indices.
        win   = rr_q;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req_valid[k] && OW'(k) >= rr_q) begin
                found = 1'b1;
                win   = OW'(k);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req_valid[k]) begin
                found = 1'b1;
                win   = OW'(k);
            end
        end
        nxt = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            txd_q   <= 8'h00;
            txv_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            if (xfer) begin
                txd_q <= own_d;
                txv_q <= 1'b1;
            end else if (bus.tx_ready) begin
                txv_q <= 1'b0;
            end
`ifdef UART_ARB_TIMEOUT_EN
            tmo_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (|bus.req_valid) begin
                        owner_q <= win;
                        state_q <= LOCK;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_q <= '0;
`endif
                end
                LOCK: begin
                    if (xfer && own_l) begin
                        state_q <= IDLE;
                        rr_q    <= nxt;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    // Only owner silence counts; a stalled tx_ready does not.
                    if (own_v) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        rr_q    <= nxt;
                        tmo_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign owner        = owner_q;
    assign locked       = (state_q == LOCK);
    assign bus.tx_data  = txd_q;
    assign bus.tx_valid = txv_q;

`ifdef UART_ARB_TIMEOUT_EN
    assign timeout = tmo_q;
`else
    assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with three requesters.
// A paced uart_tx ready model stands in for the transmitter.
module tb_uart_tx_arbiter;
    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] owner;
    logic       locked;
    logic       timeout;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .owner   (owner),
        .locked  (locked),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         nbytes = 0;
    int         tmo_cnt = 0;
    logic [7:0] exp_q[$];
    int         grant_q[$];
    logic [8:0] rq[N][$];
    logic [N-1:0] acc = '0;
    logic       hs = 1'b0;
    logic       chk_rel = 1'b0;
    logic       locked_p = 1'b0;
    bit         model_en = 1'b1;
    int         busy = 0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, want);
        end
    endtask

    // Monitor: pops the expected byte/grant whenever the DUT presents one.
    always @(negedge clk) begin
        acc = bus.req_valid & bus.req_ready;
        hs  = rst_n && bus.tx_valid && bus.tx_ready;
        if (chk_rel) check("release after last", locked, 0);
        chk_rel = rst_n && (|(acc & bus.req_last));
        if (hs) begin
            nbytes++;
            check("byte expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0)
                check("tx byte", bus.tx_data, exp_q.pop_front());
        end
        if (locked && !locked_p) begin
            check("grant expected", grant_q.size() > 0, 1);
            if (grant_q.size() > 0)
                check("grant owner", owner, grant_q.pop_front());
        end
        locked_p = locked;
        if (timeout) tmo_cnt++;
    end

    // Requester and uart_tx drivers, updated just after each rising edge.
    always begin
        logic [8:0] e;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (model_en) begin
            if (busy > 0) busy--;
            if (hs) busy = 40;
            bus.tx_ready = (busy <= 4);
        end
        for (int i = 0; i < N; i++) begin
            e = (rq[i].size() > 0) ? rq[i][0] : 9'h000;
            bus.req_valid[i]       = rq[i].size() > 0;
            bus.req_last[i]        = e[8];
            bus.req_data[8*i +: 8] = e[7:0];
        end
    end

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || grant_q.size() != 0 || locked ||
                rq[0].size() + rq[1].size() + rq[2].size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(nm, n < 3000, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_txv(input string nm);
        int n = 0;
        while (!bus.tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(nm, bus.tx_valid, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        int nb0;
        int n;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.tx_ready  = 1'b1;

        #1;
        check("rst locked", locked, 0);
        check("rst tx_valid", bus.tx_valid, 0);
        check("rst tx_data", bus.tx_data, 0);
        check("rst req_ready", bus.req_ready, 0);
        check("rst owner", owner, 0);
        check("rst timeout", timeout, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single requester, 3-byte packet, first-byte latency.
        @(negedge clk);
        rq[0].push_back({1'b0, 8'h41});
        rq[0].push_back({1'b0, 8'h42});
        rq[0].push_back({1'b1, 8'h43});
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        grant_q.push_back(0);
        @(negedge clk);
        check("lat t locked", locked, 0);
        @(negedge clk);
        check("lat t+1 locked", locked, 1);
        check("lat t+1 tx_valid", bus.tx_valid, 0);
        check("lat t+1 req_ready", bus.req_ready, 3'b001);
        @(negedge clk);
        check("lat t+2 tx_valid", bus.tx_valid, 1);
        check("lat t+2 tx_data", bus.tx_data, 8'h41);
        wait_drain("single drain");

        // All three valid from reset: grants 0,1,2,0 without interleave.
        rst_n = 1'b0;
        rq[0].push_back({1'b0, 8'h10});
        rq[0].push_back({1'b1, 8'h11});
        rq[0].push_back({1'b0, 8'h12});
        rq[0].push_back({1'b1, 8'h13});
        rq[1].push_back({1'b0, 8'h20});
        rq[1].push_back({1'b1, 8'h21});
        rq[2].push_back({1'b0, 8'h30});
        rq[2].push_back({1'b1, 8'h31});
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h12, 8'h13};
        grant_q = '{0, 1, 2, 0};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_drain("rr drain");

`ifndef UART_ARB_TIMEOUT_EN
        // Owner 1 pauses 50 cycles mid-packet while requester 0 waits.
        @(negedge clk);
        rq[1].push_back({1'b0, 8'h51});
        rq[0].push_back({1'b0, 8'h61});
        rq[0].push_back({1'b1, 8'h62});
        exp_q = '{8'h51, 8'h52, 8'h61, 8'h62};
        grant_q = '{1, 0};
        n = 0;
        while (rq[1].size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pause first byte", rq[1].size(), 0);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.req_ready[0] !== 1'b0 || locked !== 1'b1 || owner !== 2'd1)
                bad++;
        end
        check("pause hold", bad, 0);
        rq[1].push_back({1'b1, 8'h52});
        wait_drain("pause drain");
`endif

        // tx_ready held low 20 cycles with 0x5A in the holding register.
        model_en     = 1'b0;
        bus.tx_ready = 1'b0;
        rq[2].push_back({1'b0, 8'h5A});
        rq[2].push_back({1'b1, 8'h5B});
        exp_q = '{8'h5A, 8'h5B};
        grant_q = '{2};
        wait_txv("stall valid");
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.tx_data !== 8'h5A || bus.tx_valid !== 1'b1 ||
                bus.req_ready[2] !== 1'b0)
                bad++;
        end
        check("stall hold", bad, 0);
        nb0 = nbytes;
        @(posedge clk);
        #1;
        bus.tx_ready = 1'b1;
        @(negedge clk);
        #1;
        check("stall first ready", nbytes, nb0 + 1);
        wait_drain("stall drain");

        // Reset mid-packet with 0x77 held: byte is discarded.
        bus.tx_ready = 1'b0;
        rq[1].push_back({1'b0, 8'h77});
        rq[1].push_back({1'b0, 8'h78});
        grant_q = '{1};
        wait_txv("hold 77 valid");
        check("hold 77 data", bus.tx_data, 8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst mid tx_valid", bus.tx_valid, 0);
        check("rst mid locked", locked, 0);
        check("rst mid req_ready", bus.req_ready, 0);
        rq[1].delete();
        nb0 = nbytes;
        bus.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("77 never sent", nbytes, nb0);
        check("rst idle tx_valid", bus.tx_valid, 0);

`ifdef UART_ARB_TIMEOUT_EN
        // Owner 0 stalls mid-packet; forced release after 16 idle cycles.
        rq[0].push_back({1'b0, 8'h81});
        rq[1].push_back({1'b0, 8'h91});
        rq[1].push_back({1'b1, 8'h92});
        exp_q = '{8'h81, 8'h91, 8'h92};
        grant_q = '{0, 1};
        n = 0;
        while (rq[0].size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tmo first byte", rq[0].size(), 0);
        n = 0;
        while (!timeout && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("tmo idle cycles", n, 16);
        check("tmo unlocked", locked, 0);
        @(negedge clk);
        check("tmo one pulse", timeout, 0);
        check("tmo regrant", locked, 1);
        check("tmo new owner", owner, 1);
        wait_drain("tmo drain");
        check("timeout pulses", tmo_cnt, 1);
`else
        check("timeout never", tmo_cnt, 0);
`endif

        model_en = 1'b1;
        repeat (5) @(negedge clk);
        check("bytes left", exp_q.size(), 0);
        check("grants left", grant_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
